ascon_mode_controller: RTL

//  Parametrised sequencer for the Ascon datapath: AEAD encrypt, AEAD decrypt and hash.

---
 rtl/ascon_pkg.sv | 39 +++
 rtl/ascon_blk_counter.sv | 53 +++++
 rtl/ascon_mode_controller.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared encodings for the Ascon mode controller: operating modes, FSM state
// codes, reference IVs and default round counts.
package ascon_pkg;

    localparam logic [1:0] MODE_ENC  = 2'b00;
    localparam logic [1:0] MODE_DEC  = 2'b01;
    localparam logic [1:0] MODE_HASH = 2'b10;
    localparam logic [1:0] MODE_ILL  = 2'b11;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOAD   = 4'd1;
    localparam logic [3:0] ST_INIT_P = 4'd2;
    localparam logic [3:0] ST_KEYX   = 4'd3;
    localparam logic [3:0] ST_AD_IN  = 4'd4;
    localparam logic [3:0] ST_AD_P   = 4'd5;
    localparam logic [3:0] ST_DSEP   = 4'd6;
    localparam logic [3:0] ST_MSG_IN = 4'd7;
    localparam logic [3:0] ST_MSG_OUT= 4'd8;
    localparam logic [3:0] ST_MSG_P  = 4'd9;
    localparam logic [3:0] ST_FKEYX  = 4'd10;
    localparam logic [3:0] ST_FIN_P  = 4'd11;
    localparam logic [3:0] ST_TAG    = 4'd12;
    localparam logic [3:0] ST_SQZ    = 4'd13;
    localparam logic [3:0] ST_SQZ_P  = 4'd14;
    localparam logic [3:0] ST_DONE   = 4'd15;

    // IVs the datapath loads when load_length pulses.
    localparam logic [63:0] IV_ASCON128  = 64'h80400c0600000000;
    localparam logic [63:0] IV_ASCON128A = 64'h80800c0800000000;
    localparam logic [63:0] IV_HASH      = 64'h00400c0000000100;

    localparam int DEF_ROUNDS_A = 12;
    localparam int DEF_ROUNDS_B = 6;

    function automatic logic is_perm_state(input logic [3:0] st);
        return st inside {ST_INIT_P, ST_AD_P, ST_MSG_P, ST_FIN_P, ST_SQZ_P};
    endfunction

endpackage

// File: rtl/ascon_blk_counter.sv
// Block counter for one data phase: captures a byte length and reports whether
// the current block is the last one and how many bytes it carries.
module ascon_blk_counter
    import ascon_pkg::*;
#(
    parameter int RATE_BYTES = 8,
    parameter int LEN_W      = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              load_i,
    input  logic [LEN_W-1:0]                  len_i,
    input  logic                              adv_i,
    output logic                              last_o,
    output logic [$clog2(RATE_BYTES+1)-1:0]   bytes_o
);

    localparam int RATE_LOG = $clog2(RATE_BYTES);
    localparam int CNT_W    = LEN_W - RATE_LOG + 1;
    localparam int BB_W     = $clog2(RATE_BYTES + 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RATE_LOG-1:0] tail_q, tail_d;

    // Blocks remaining including the current one; the spare top bit keeps an
    // all-ones length from wrapping when the pad-only block is added.
    always_comb begin
        cnt_d  = cnt_q;
        tail_d = tail_q;
        if (load_i) begin
            cnt_d  = CNT_W'(len_i >> RATE_LOG) + CNT_W'(1);
            tail_d = len_i[RATE_LOG-1:0];
        end else if (adv_i) begin
            cnt_d  = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: these are control registers, not a storage array, so every flop
    // takes the asynchronous reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tail_q <= tail_d;
        end
    end

    assign last_o  = (cnt_q == CNT_W'(1));
    assign bytes_o = last_o ? BB_W'(tail_q) : BB_W'(RATE_BYTES);

endmodule

// File: rtl/ascon_mode_controller.sv
// Sequencer for the Ascon datapath (AEAD encrypt/decrypt and hash): walks the
// permutation/absorb/squeeze schedule and drives the datapath strobes.
module ascon_mode_controller
    import ascon_pkg::*;
#(
    parameter int RATE_BYTES = 8,
    parameter int ROUNDS_A   = DEF_ROUNDS_A,
    parameter int ROUNDS_B   = DEF_ROUNDS_B,
    parameter int LEN_W      = 16,
    parameter int HASH_OUT   = 32
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              start,
    input  logic [1:0]                        mode,
    input  logic [LEN_W-1:0]                  ad_len,
    input  logic [LEN_W-1:0]                  msg_len,
    input  logic                              blk_valid,
    output logic                              blk_ready,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic                              perm_start,
    output logic [3:0]                        perm_rounds,
    input  logic                              perm_done,
    output logic                              load_length,
    output logic                              load_data_in,
    output logic [$clog2(RATE_BYTES+1)-1:0]   blk_bytes,
    output logic                              phase_msg,
    output logic                              dom_sep,
    output logic                              key_xor,
    input  logic                              tag_match,
    output logic                              done,
    output logic                              auth_fail,
    output logic                              err
);

    localparam int         BB_W     = $clog2(RATE_BYTES + 1);
    localparam int         SQZ_BLKS = HASH_OUT / RATE_BYTES;
    localparam int         SQZ_W    = $clog2(SQZ_BLKS + 1);
    localparam logic [3:0] RA       = 4'(ROUNDS_A);
    localparam logic [3:0] RB       = 4'(ROUNDS_B);

    logic [3:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic             perm_issued_q, perm_issued_d;
    logic             auth_fail_q, auth_fail_d;
    logic             err_q, err_d;
    logic [SQZ_W-1:0] sqz_cnt_q, sqz_cnt_d;

    logic            start_ok, in_perm, perm_fire, is_hash, is_dec;
    logic            ad_last, ad_zero, ad_adv, msg_last, msg_adv;
    logic [BB_W-1:0] ad_bytes, msg_bytes;

    assign start_ok = (state_q == ST_IDLE) && start;
    assign is_hash  = (mode_q == MODE_HASH);
    assign is_dec   = (mode_q == MODE_DEC);
    assign in_perm  = is_perm_state(state_q);
    // The request goes out on the first cycle in a *_P state; completions are
    // honoured only after that request.
    assign perm_start   = in_perm && !perm_issued_q;
    assign perm_fire    = in_perm && perm_issued_q && perm_done;
    assign load_data_in = blk_valid && blk_ready;
    assign ad_zero      = ad_last && (ad_bytes == '0);
    assign auth_fail    = auth_fail_q;
    assign err          = err_q;

    ascon_blk_counter #(.RATE_BYTES(RATE_BYTES), .LEN_W(LEN_W)) u_ad_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (start_ok),
        .len_i   (ad_len),
        .adv_i   (ad_adv),
        .last_o  (ad_last),
        .bytes_o (ad_bytes)
    );

    ascon_blk_counter #(.RATE_BYTES(RATE_BYTES), .LEN_W(LEN_W)) u_msg_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (start_ok),
        .len_i   (msg_len),
        .adv_i   (msg_adv),
        .last_o  (msg_last),
        .bytes_o (msg_bytes)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        auth_fail_d   = auth_fail_q;
        err_d         = err_q;
        sqz_cnt_d     = sqz_cnt_q;
        perm_issued_d = in_perm && !perm_fire;
        blk_ready     = 1'b0;
        out_valid     = 1'b0;
        load_length   = 1'b0;
        dom_sep       = 1'b0;
        key_xor       = 1'b0;
        done          = 1'b0;
        blk_bytes     = '0;
        phase_msg     = 1'b0;
        perm_rounds   = '0;
        ad_adv        = 1'b0;
        msg_adv       = 1'b0;

        case (state_q)
            ST_IDLE: if (start) begin
                mode_d      = mode;
                auth_fail_d = 1'b0;
                err_d       = (mode == MODE_ILL);
                sqz_cnt_d   = SQZ_W'(SQZ_BLKS - 1);
                state_d     = (mode == MODE_ILL) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                load_length = 1'b1;
                state_d     = ST_INIT_P;
            end
            ST_INIT_P: begin
                perm_rounds = RA;
                if (perm_fire) state_d = is_hash ? ST_MSG_IN : ST_KEYX;
            end
            ST_KEYX: begin
                key_xor = 1'b1;
                state_d = ad_zero ? ST_DSEP : ST_AD_IN;
            end
            ST_AD_IN: begin
                blk_ready = 1'b1;
                blk_bytes = ad_bytes;
                if (blk_valid) state_d = ST_AD_P;
            end
            ST_AD_P: begin
                perm_rounds = RB;
                if (perm_fire) begin
                    ad_adv  = 1'b1;
                    state_d = ad_last ? ST_DSEP : ST_AD_IN;
                end
            end
            ST_DSEP: begin
                dom_sep = 1'b1;
                state_d = ST_MSG_IN;
            end
            ST_MSG_IN: begin
                blk_ready = 1'b1;
                phase_msg = 1'b1;
                blk_bytes = msg_bytes;
                if (blk_valid) begin
                    if (is_hash) state_d = msg_last ? ST_FIN_P : ST_MSG_P;
                    else         state_d = ST_MSG_OUT;
                end
            end
            ST_MSG_OUT: begin
                out_valid = 1'b1;
                phase_msg = 1'b1;
                if (out_ready) state_d = msg_last ? ST_FKEYX : ST_MSG_P;
            end
            ST_MSG_P: begin
                phase_msg   = 1'b1;
                perm_rounds = is_hash ? RA : RB;
                if (perm_fire) begin
                    msg_adv = 1'b1;
                    state_d = ST_MSG_IN;
                end
            end
            ST_FKEYX: begin
                key_xor = 1'b1;
                state_d = ST_FIN_P;
            end
            ST_FIN_P: begin
                perm_rounds = RA;
                if (perm_fire) state_d = is_hash ? ST_SQZ : ST_TAG;
            end
            ST_TAG: begin
                if (is_dec) begin
                    auth_fail_d = !tag_match;
                    state_d     = ST_DONE;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) state_d = ST_DONE;
                end
            end
            ST_SQZ: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (sqz_cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        sqz_cnt_d = sqz_cnt_q - SQZ_W'(1);
                        state_d   = ST_SQZ_P;
                    end
                end
            end
            ST_SQZ_P: begin
                perm_rounds = RA;
                if (perm_fire) state_d = ST_SQZ;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only;
    // the blocking assignments above are confined to combinational logic.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_ENC;
            perm_issued_q <= 1'b0;
            auth_fail_q   <= 1'b0;
            err_q         <= 1'b0;
            sqz_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            perm_issued_q <= perm_issued_d;
            auth_fail_q   <= auth_fail_d;
            err_q         <= err_d;
            sqz_cnt_q     <= sqz_cnt_d;
        end
    end

endmodule
